// File: rtl/mipspipe_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// State encoding and requester (owner) encoding.
package mipspipe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Word address from a byte address.
    function automatic logic [29:0] word_of(input logic [31:0] a);
        return a[31:2];
    endfunction

endpackage

// File: rtl/mipspipe_arb_pick.sv
// Grant selection between the IF and data requesters (combinational).
// Ports:
//   if_req, d_req  : pending requests
//   last_owner     : requester granted most recently
//   grant_valid    : some request is pending
//   grant_owner    : OWN_IF / OWN_D
// Build option ARB_RR_EN: alternate on simultaneous requests;
// otherwise the data requester always wins a tie.
module mipspipe_arb_pick
    import mipspipe_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = if_req | d_req;

`ifdef ARB_RR_EN
    // Tie goes to whoever was not served last.
    always_comb begin
        grant_owner = OWN_IF;
        if (if_req && d_req)
            grant_owner = ~last_owner;
        else if (d_req)
            grant_owner = OWN_D;
    end
`else
    // Data access belongs to the older instruction.
    logic w_unused_last;
    assign w_unused_last = last_owner;

    always_comb begin
        grant_owner = OWN_IF;
        if (d_req)
            grant_owner = OWN_D;
    end
`endif

endmodule

// File: rtl/mipspipe_mem_arbiter.sv
// Arbiter sharing one multi-cycle single-port memory between IF and MEM.
// Ports: clock/reset (async, active-high); IF side if_req/if_addr ->
//   if_done/if_rdata; data side d_req/d_we/d_addr/d_wdata -> d_done/
//   d_rdata; memory side mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata;
//   pipe_stall freezes the pipeline while any request is outstanding.
// Build option ARB_RR_EN selects round-robin tie breaking.
module mipspipe_mem_arbiter
    import mipspipe_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WAIT_CYC = 2
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pipe_stall
);

    localparam int CW = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;

    logic          r_owner;
    logic          r_last_owner;
    logic          r_we;
    logic [AW-3:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_if_done;
    logic          r_d_done;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_gnt_valid;
    logic          w_gnt_owner;
    logic          w_grant;
    logic          w_acc_last;
    logic          w_sel_we;
    logic          w_unused_lsb;

    assign w_unused_lsb = ^{if_addr[1:0], d_addr[1:0]};

    mipspipe_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_owner  (r_last_owner),
        .grant_valid (w_gnt_valid),
        .grant_owner (w_gnt_owner)
    );

    assign w_sel_we = (w_gnt_owner == OWN_D) & d_we;

    // Next-state and strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_acc_last  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_acc_last  = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Wait-state counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_grant)
            r_cnt <= CNT_LOAD;
        else if (r_state == ACCESS && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // Latched copy of the granted request; owner inputs are
    // ignored afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_owner      <= w_gnt_owner;
            r_last_owner <= w_gnt_owner;
            r_we         <= w_sel_we;
            if (w_gnt_owner == OWN_D) begin
                r_addr  <= d_addr[AW-1:2];
                r_wdata <= d_wdata;
            end else begin
                r_addr  <= if_addr[AW-1:2];
                r_wdata <= '0;
            end
        end
    end

    // Memory strobes span exactly the ACCESS cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
        end else if (w_grant) begin
            r_mem_en <= 1'b1;
            r_mem_we <= w_sel_we;
        end else if (w_acc_last) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
        end
    end

    // Completion pulses and read-data capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            if (w_acc_last) begin
                if (r_owner == OWN_D) begin
                    r_d_done <= 1'b1;
                    if (!r_we)
                        r_d_rdata <= mem_rdata;
                end else begin
                    r_if_done <= 1'b1;
                    if (!r_we)
                        r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign if_done    = r_if_done;
    assign d_done     = r_d_done;
    assign if_rdata   = r_if_rdata;
    assign d_rdata    = r_d_rdata;

    assign pipe_stall = (if_req & ~r_if_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_mipspipe_mem_arbiter.sv
// Directed bench for mipspipe_mem_arbiter (WAIT_CYC=2 and WAIT_CYC=1).
// Bit k of each trace vector is the value seen in cycle k.
module tb_mipspipe_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pipe_stall;

    logic        if_req2 = 1'b0;
    logic [31:0] if_addr2 = '0;
    logic        if_done2;
    logic [31:0] if_rdata2;
    logic        d_req2 = 1'b0;
    logic        d_we2 = 1'b0;
    logic [31:0] d_addr2 = '0;
    logic [31:0] d_wdata2 = '0;
    logic        d_done2;
    logic [31:0] d_rdata2;
    logic        mem_en2;
    logic        mem_we2;
    logic [29:0] mem_addr2;
    logic [31:0] mem_wdata2;
    logic [31:0] mem_rdata2;
    logic        pipe_stall2;

    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_a = '0;
    logic [31:0] pre_d = '0;

    int errors = 0;
    int checks = 0;

    logic [15:0] v_en, v_we, v_ifd, v_dd, v_st;
    logic [29:0] s_addr [16];

    always #5 clock = ~clock;

    assign mem_rdata  = mem[mem_addr[5:0]];
    assign mem_rdata2 = {2'b10, mem_addr2};

    always @(posedge clock) begin
        if (mem_en && mem_we)
            mem[mem_addr[5:0]] <= mem_wdata;
        else if (pre_we)
            mem[pre_a] <= pre_d;
    end

    mipspipe_mem_arbiter #(.AW(32), .DW(32), .WAIT_CYC(2)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pipe_stall(pipe_stall)
    );

    mipspipe_mem_arbiter #(.AW(32), .DW(32), .WAIT_CYC(1)) dut1 (
        .clock(clock), .reset(reset),
        .if_req(if_req2), .if_addr(if_addr2),
        .if_done(if_done2), .if_rdata(if_rdata2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_done(d_done2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .pipe_stall(pipe_stall2)
    );

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_a = a;
        pre_d = d;
        pre_we = 1'b1;
        @(posedge clock);
        #1;
        pre_we = 1'b0;
    endtask

    // Trace n cycles starting at the current one; a requester drops
    // its req on the edge that ends its done cycle.
    task automatic run(input int n);
        logic drop_if, drop_d;
        v_en = '0; v_we = '0; v_ifd = '0; v_dd = '0; v_st = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            v_en[k]   = mem_en;
            v_we[k]   = mem_we;
            v_ifd[k]  = if_done;
            v_dd[k]   = d_done;
            v_st[k]   = pipe_stall;
            s_addr[k] = mem_addr;
            drop_if   = if_done;
            drop_d    = d_done;
            @(posedge clock);
            #1;
            if (drop_if) if_req = 1'b0;
            if (drop_d) d_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        preload(6'd0, 32'h00000123);
        preload(6'd2, 32'h8ca30004);
        preload(6'd4, 32'hfffffffe);
        preload(6'd5, 32'h00000000);
        preload(6'd6, 32'h13572468);
        preload(6'd7, 32'h000000aa);
        reset = 1'b0;
        @(negedge clock);
        checks += 9;
        if (if_done !== 1'b0) begin errors++; $display("FAIL rst_if_done: got %b want 0", if_done); end
        if (d_done !== 1'b0) begin errors++; $display("FAIL rst_d_done: got %b want 0", d_done); end
        if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
        if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 30'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", pipe_stall); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_fetch;
        if_addr = 32'h8;
        if_req = 1'b1;
        run(8);
        checks += 6;
        if (v_en[7:0] !== 8'b0000_0110) begin errors++; $display("FAIL t1_en: got %b want 00000110", v_en[7:0]); end
        if (s_addr[1] !== 30'd2 || s_addr[2] !== 30'd2) begin errors++; $display("FAIL t1_addr: got %0d/%0d want 2/2", s_addr[1], s_addr[2]); end
        if (v_ifd[7:0] !== 8'b0000_1000) begin errors++; $display("FAIL t1_if_done: got %b want 00001000", v_ifd[7:0]); end
        if (v_dd[7:0] !== 8'b0) begin errors++; $display("FAIL t1_d_done: got %b want 00000000", v_dd[7:0]); end
        if (v_st[7:0] !== 8'b0000_0111) begin errors++; $display("FAIL t1_stall: got %b want 00000111", v_st[7:0]); end
        if (if_rdata !== 32'h8ca30004) begin errors++; $display("FAIL t1_rdata: got %h want 8ca30004", if_rdata); end
    endtask

    task automatic test_conflict;
        if_addr = 32'h0;
        d_addr = 32'h10;
        d_we = 1'b0;
        if_req = 1'b1;
        d_req = 1'b1;
        run(10);
        checks += 8;
        if (v_dd[9:0] !== 10'b00_0000_1000) begin errors++; $display("FAIL t2_d_done: got %b want 0000001000", v_dd[9:0]); end
        if (v_ifd[9:0] !== 10'b00_1000_0000) begin errors++; $display("FAIL t2_if_done: got %b want 0010000000", v_ifd[9:0]); end
        if (v_en[9:0] !== 10'b00_0110_0110) begin errors++; $display("FAIL t2_en: got %b want 0001100110", v_en[9:0]); end
        if (v_st[9:0] !== 10'b00_0111_1111) begin errors++; $display("FAIL t2_stall: got %b want 0001111111", v_st[9:0]); end
        if (s_addr[1] !== 30'd4) begin errors++; $display("FAIL t2_d_addr: got %0d want 4", s_addr[1]); end
        if (s_addr[5] !== 30'd0) begin errors++; $display("FAIL t2_if_addr: got %0d want 0", s_addr[5]); end
        if (d_rdata !== 32'hfffffffe) begin errors++; $display("FAIL t2_d_rdata: got %h want fffffffe", d_rdata); end
        if (if_rdata !== 32'h00000123) begin errors++; $display("FAIL t2_if_rdata: got %h want 00000123", if_rdata); end
    endtask

`ifdef ARB_RR_EN
    localparam logic [9:0] EXP3_IFD = 10'b00_0000_1000;
    localparam logic [9:0] EXP3_DD  = 10'b00_1000_0000;
`else
    localparam logic [9:0] EXP3_IFD = 10'b00_1000_0000;
    localparam logic [9:0] EXP3_DD  = 10'b00_0000_1000;
`endif

    task automatic test_arb_order;
        d_addr = 32'h18;
        d_we = 1'b0;
        d_req = 1'b1;
        run(6);
        checks += 4;
        if (v_dd[5:0] !== 6'b00_1000) begin errors++; $display("FAIL t3_single: got %b want 001000", v_dd[5:0]); end
        if_addr = 32'h8;
        if_req = 1'b1;
        d_req = 1'b1;
        run(10);
        if (v_ifd[9:0] !== EXP3_IFD) begin errors++; $display("FAIL t3_if_done: got %b want %b", v_ifd[9:0], EXP3_IFD); end
        if (v_dd[9:0] !== EXP3_DD) begin errors++; $display("FAIL t3_d_done: got %b want %b", v_dd[9:0], EXP3_DD); end
        if (d_rdata !== 32'h13572468) begin errors++; $display("FAIL t3_d_rdata: got %h want 13572468", d_rdata); end
    endtask

    task automatic test_store;
        d_addr = 32'h14;
        d_wdata = 32'hffffffff;
        d_we = 1'b1;
        d_req = 1'b1;
        run(6);
        checks += 7;
        if (v_we[5:0] !== 6'b00_0110) begin errors++; $display("FAIL t4_we: got %b want 000110", v_we[5:0]); end
        if (v_en[5:0] !== 6'b00_0110) begin errors++; $display("FAIL t4_en: got %b want 000110", v_en[5:0]); end
        if (v_dd[5:0] !== 6'b00_1000) begin errors++; $display("FAIL t4_d_done: got %b want 001000", v_dd[5:0]); end
        if (d_rdata !== 32'h13572468) begin errors++; $display("FAIL t4_rdata_hold: got %h want 13572468", d_rdata); end
        if (mem[5] !== 32'hffffffff) begin errors++; $display("FAIL t4_mem: got %h want ffffffff", mem[5]); end
        d_we = 1'b0;
        d_wdata = 32'h0;
        d_req = 1'b1;
        run(6);
        if (v_we[5:0] !== 6'b0) begin errors++; $display("FAIL t4_lw_we: got %b want 000000", v_we[5:0]); end
        if (d_rdata !== 32'hffffffff) begin errors++; $display("FAIL t4_lw: got %h want ffffffff", d_rdata); end
    endtask

    task automatic test_wait1;
        if_addr2 = 32'h40;
        if_req2 = 1'b1;
        v_en = '0;
        v_ifd = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            v_en[k] = mem_en2;
            v_ifd[k] = if_done2;
            @(posedge clock);
            #1;
        end
        if_req2 = 1'b0;
        checks += 3;
        if (v_ifd[9:0] !== 10'b01_0010_0100) begin errors++; $display("FAIL t6_if_done: got %b want 0100100100", v_ifd[9:0]); end
        if (v_en[9:0] !== 10'b00_1001_0010) begin errors++; $display("FAIL t6_en: got %b want 0010010010", v_en[9:0]); end
        if (if_rdata2 !== 32'h80000010) begin errors++; $display("FAIL t6_rdata: got %h want 80000010", if_rdata2); end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid;
        d_addr = 32'h1c;
        d_wdata = 32'h00000055;
        d_we = 1'b1;
        d_req = 1'b1;
        @(posedge clock);
        #2;
        checks += 7;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL t5_en_before: got %b want 1", mem_en); end
        reset = 1'b1;
        #1;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL t5_en_async: got %b want 0", mem_en); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL t5_we_async: got %b want 0", mem_we); end
        d_req = 1'b0;
        d_we = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        run(5);
        if (v_dd[4:0] !== 5'b0) begin errors++; $display("FAIL t5_no_done: got %b want 00000", v_dd[4:0]); end
        if (v_en[4:0] !== 5'b0) begin errors++; $display("FAIL t5_idle: got %b want 00000", v_en[4:0]); end
        if (mem[7] !== 32'h000000aa) begin errors++; $display("FAIL t5_mem: got %h want 000000aa", mem[7]); end
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL t5_rdata: got %h want 0", d_rdata); end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_conflict;
        test_arb_order;
        test_store;
        test_wait1;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
